// File: rtl/mwc_pkg.sv
// mwc_pkg: shared types for the memory write checker.
//   state_t      - checker FSM states
//   fail_code_t  - failure cause codes reported on fail_code
package mwc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    PASS  = 2'd2,
    FAIL  = 2'd3
  } state_t;

  typedef logic [2:0] fail_code_t;

  localparam fail_code_t FC_NONE     = 3'd0;
  localparam fail_code_t FC_BAD_ADDR = 3'd1;
  localparam fail_code_t FC_BAD_DATA = 3'd2;
  localparam fail_code_t FC_TIMEOUT  = 3'd3;
  localparam fail_code_t FC_BAD_CFG  = 3'd4;

endpackage

// File: rtl/mwc_table.sv
// mwc_table: expected (address, data) table for the memory write checker.
// DEPTH entries of {addr, data}, one synchronous write port and one
// combinational read port. Contents are deliberately not reset so a table
// survives a checker reset.
//   clk        in  clock
//   we         in  write enable
//   wr_idx     in  write index
//   wr_addr    in  address to store in entry wr_idx
//   wr_data    in  data to store in entry wr_idx
//   rd_idx     in  read index
//   rd_addr_c  out entry address at rd_idx (combinational)
//   rd_data_c  out entry data at rd_idx (combinational)
module mwc_table #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       we,
  input  logic [$clog2(DEPTH)-1:0]   wr_idx,
  input  logic [WIDTH-1:0]           wr_addr,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic [$clog2(DEPTH)-1:0]   rd_idx,
  output logic [WIDTH-1:0]           rd_addr_c,
  output logic [WIDTH-1:0]           rd_data_c
);

  logic [WIDTH-1:0] addr_mem [DEPTH];
  logic [WIDTH-1:0] data_mem [DEPTH];

  // Write port
  always_ff @(posedge clk) begin
    if (we) begin
      addr_mem[wr_idx] <= wr_addr;
      data_mem[wr_idx] <= wr_data;
    end
  end

  // Read port
  assign rd_addr_c = addr_mem[rd_idx];
  assign rd_data_c = data_mem[rd_idx];

endmodule

// File: rtl/mem_write_checker.sv
// mem_write_checker: snoops the data-memory write port and checks stores
// in order against a programmable table of expected (address, data) pairs.
//   clk          in  clock, rising edge
//   reset        in  asynchronous active-low reset
//   memwrite     in  store strobe
//   dataadr      in  store address
//   writedata    in  store data
//   exp_we       in  table write enable (ignored while ARMED)
//   exp_idx      in  table write index
//   exp_addr     in  expected address for entry
//   exp_data     in  expected data for entry
//   num_exp      in  number of valid entries (1..DEPTH)
//   start        in  arm pulse
//   done         out checker reached PASS or FAIL
//   pass         out all entries matched
//   fail         out failure detected
//   fail_code    out failure cause
//   fail_addr    out offending store address (0 for timeout/config)
//   fail_data    out offending store data (0 for timeout/config)
//   match_count  out entries matched so far
module mem_write_checker
  import mwc_pkg::*;
#(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned TIMEOUT  = 4096,
  parameter int unsigned IGN_ADDR = 80
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       memwrite,
  input  logic [WIDTH-1:0]           dataadr,
  input  logic [WIDTH-1:0]           writedata,
  input  logic                       exp_we,
  input  logic [$clog2(DEPTH)-1:0]   exp_idx,
  input  logic [WIDTH-1:0]           exp_addr,
  input  logic [WIDTH-1:0]           exp_data,
  input  logic [$clog2(DEPTH):0]     num_exp,
  input  logic                       start,
  output logic                       done,
  output logic                       pass,
  output logic                       fail,
  output logic [2:0]                 fail_code,
  output logic [WIDTH-1:0]           fail_addr,
  output logic [WIDTH-1:0]           fail_data,
  output logic [$clog2(DEPTH):0]     match_count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned TW = $clog2(TIMEOUT);

  // Registered state and next-state values
  state_t           state_q,     state_d;
  logic [PW-1:0]    ptr_q,       ptr_d;
  logic [TW-1:0]    cnt_q,       cnt_d;
  logic [CW-1:0]    mc_q,        mc_d;
  logic             done_q,      done_d;
  logic             pass_q,      pass_d;
  logic             fail_q,      fail_d;
  fail_code_t       code_q,      code_d;
  logic [WIDTH-1:0] faddr_q,     faddr_d;
  logic [WIDTH-1:0] fdata_q,     fdata_d;

  // Table interface
  logic             table_we_c;
  logic [WIDTH-1:0] cur_addr_c;
  logic [WIDTH-1:0] cur_data_c;

  // Store classification
  logic             addr_hit_c;
  logic             data_hit_c;
  logic             ign_hit_c;
  logic             last_entry_c;
  logic             bad_cfg_c;
  logic             cnt_expired_c;

  // Table writes are frozen while a check is in flight
  assign table_we_c = exp_we && (state_q != ARMED);

  mwc_table #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_table (
    .clk       (clk),
    .we        (table_we_c),
    .wr_idx    (exp_idx),
    .wr_addr   (exp_addr),
    .wr_data   (exp_data),
    .rd_idx    (ptr_q),
    .rd_addr_c (cur_addr_c),
    .rd_data_c (cur_data_c)
  );

  assign addr_hit_c    = (dataadr == cur_addr_c);
  assign data_hit_c    = (writedata == cur_data_c);
  assign ign_hit_c     = (dataadr == WIDTH'(IGN_ADDR));
  // Compare against the count rather than the pointer so num_exp==DEPTH works
  assign last_entry_c  = ((mc_q + CW'(1)) == num_exp);
  assign bad_cfg_c     = (num_exp == '0) || (num_exp > CW'(DEPTH));
  assign cnt_expired_c = (cnt_q == TW'(TIMEOUT - 1));

  // State and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      mc_q    <= '0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
      code_q  <= FC_NONE;
      faddr_q <= '0;
      fdata_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      mc_q    <= mc_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
      code_q  <= code_d;
      faddr_q <= faddr_d;
      fdata_q <= fdata_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    mc_d    = mc_q;
    done_d  = done_q;
    pass_d  = pass_q;
    fail_d  = fail_q;
    code_d  = code_q;
    faddr_d = faddr_q;
    fdata_d = fdata_q;

    case (state_q)
      IDLE, PASS, FAIL: begin
        if (start) begin
          ptr_d   = '0;
          cnt_d   = '0;
          mc_d    = '0;
          pass_d  = 1'b0;
          faddr_d = '0;
          fdata_d = '0;
          if (bad_cfg_c) begin
            state_d = FAIL;
            done_d  = 1'b1;
            fail_d  = 1'b1;
            code_d  = FC_BAD_CFG;
          end else begin
            state_d = ARMED;
            done_d  = 1'b0;
            fail_d  = 1'b0;
            code_d  = FC_NONE;
          end
        end
      end

      ARMED: begin
        cnt_d = cnt_q + TW'(1);

        // Store evaluation: match, then scratch ignore, then mismatch
        if (memwrite) begin
          if (addr_hit_c && data_hit_c) begin
            ptr_d = ptr_q + PW'(1);
            mc_d  = mc_q + CW'(1);
            if (last_entry_c) begin
              state_d = PASS;
              done_d  = 1'b1;
              pass_d  = 1'b1;
            end
          end else if (!ign_hit_c) begin
            state_d = FAIL;
            done_d  = 1'b1;
            fail_d  = 1'b1;
            code_d  = addr_hit_c ? FC_BAD_DATA : FC_BAD_ADDR;
            faddr_d = dataadr;
            fdata_d = writedata;
          end
        end

        // Timeout only applies if the store did not already resolve the check
        if ((state_d == ARMED) && cnt_expired_c) begin
          state_d = FAIL;
          done_d  = 1'b1;
          fail_d  = 1'b1;
          code_d  = FC_TIMEOUT;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign done        = done_q;
  assign pass        = pass_q;
  assign fail        = fail_q;
  assign fail_code   = code_q;
  assign fail_addr   = faddr_q;
  assign fail_data   = fdata_q;
  assign match_count = mc_q;

endmodule

// File: tb/tb_mem_write_checker.sv
// tb_mem_write_checker: directed plus randomized bench for mem_write_checker
// with a behavioural reference model of the checking rules.
module tb_mem_write_checker;

  localparam int unsigned W   = 32;
  localparam int unsigned D   = 8;
  localparam int unsigned TO  = 16;
  localparam int unsigned IGN = 80;

  localparam int MS_IDLE  = 0;
  localparam int MS_ARMED = 1;
  localparam int MS_PASS  = 2;
  localparam int MS_FAIL  = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          memwrite;
  logic [W-1:0]  dataadr;
  logic [W-1:0]  writedata;
  logic          exp_we;
  logic [2:0]    exp_idx;
  logic [W-1:0]  exp_addr;
  logic [W-1:0]  exp_data;
  logic [3:0]    num_exp;
  logic          start;
  logic          done;
  logic          pass;
  logic          fail;
  logic [2:0]    fail_code;
  logic [W-1:0]  fail_addr;
  logic [W-1:0]  fail_data;
  logic [3:0]    match_count;

  mem_write_checker #(
    .WIDTH    (W),
    .DEPTH    (D),
    .TIMEOUT  (TO),
    .IGN_ADDR (IGN)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .memwrite    (memwrite),
    .dataadr     (dataadr),
    .writedata   (writedata),
    .exp_we      (exp_we),
    .exp_idx     (exp_idx),
    .exp_addr    (exp_addr),
    .exp_data    (exp_data),
    .num_exp     (num_exp),
    .start       (start),
    .done        (done),
    .pass        (pass),
    .fail        (fail),
    .fail_code   (fail_code),
    .fail_addr   (fail_addr),
    .fail_data   (fail_data),
    .match_count (match_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: expected table plus the checker's observable outcome
  logic [W-1:0] tbl_a [D];
  logic [W-1:0] tbl_d [D];
  int           m_st, m_next, m_age, m_mc, m_code;
  bit           m_done, m_pass, m_fail;
  logic [W-1:0] m_fa, m_fd;

  function automatic void model_reset();
    m_st = MS_IDLE; m_next = 0; m_age = 0; m_mc = 0; m_code = 0;
    m_done = 0; m_pass = 0; m_fail = 0; m_fa = '0; m_fd = '0;
  endfunction

  function automatic void model_fail(input int code, input logic [W-1:0] a, input logic [W-1:0] d);
    m_st = MS_FAIL; m_done = 1; m_fail = 1; m_code = code; m_fa = a; m_fd = d;
  endfunction

  // Applies one clock edge worth of rules to the model using current inputs
  function automatic void model_edge();
    int age_now;
    if (m_st == MS_ARMED) begin
      age_now = m_age;
      m_age++;
      if (memwrite) begin
        if (dataadr == tbl_a[m_next] && writedata == tbl_d[m_next]) begin
          m_next++;
          m_mc++;
          if (m_mc == int'(num_exp)) begin
            m_st = MS_PASS; m_done = 1; m_pass = 1;
          end
        end else if (dataadr != W'(IGN)) begin
          model_fail((dataadr == tbl_a[m_next]) ? 2 : 1, dataadr, writedata);
        end
      end
      if (m_st == MS_ARMED && age_now == TO - 1) model_fail(3, '0, '0);
    end else begin
      if (exp_we) begin
        tbl_a[exp_idx] = exp_addr;
        tbl_d[exp_idx] = exp_data;
      end
      if (start) begin
        m_next = 0; m_age = 0; m_mc = 0; m_pass = 0; m_fa = '0; m_fd = '0;
        if (num_exp == 0 || num_exp > D) begin
          model_fail(4, '0, '0);
        end else begin
          m_st = MS_ARMED; m_done = 0; m_fail = 0; m_code = 0;
        end
      end
    end
  endfunction

  task automatic compare_all();
    check("done",        done,        m_done);
    check("pass",        pass,        m_pass);
    check("fail",        fail,        m_fail);
    check("fail_code",   fail_code,   m_code);
    check("match_count", match_count, m_mc);
    check("fail_addr",   fail_addr,   m_fa);
    check("fail_data",   fail_data,   m_fd);
  endtask

  // One clock: model tracks the edge, outputs sampled 1 ns later
  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic idle(input int n);
    repeat (n) cyc();
  endtask

  task automatic load(input int idx, input logic [W-1:0] a, input logic [W-1:0] d);
    exp_we = 1'b1; exp_idx = 3'(idx); exp_addr = a; exp_data = d;
    cyc();
    exp_we = 1'b0;
  endtask

  task automatic do_start(input int n);
    num_exp = 4'(n); start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic store(input logic [W-1:0] a, input logic [W-1:0] d);
    memwrite = 1'b1; dataadr = a; writedata = d;
    cyc();
    memwrite = 1'b0;
  endtask

  initial begin
    reset = 1'b0; memwrite = 1'b0; dataadr = '0; writedata = '0;
    exp_we = 1'b0; exp_idx = '0; exp_addr = '0; exp_data = '0;
    num_exp = 4'd1; start = 1'b0;
    for (int i = 0; i < D; i++) begin tbl_a[i] = '0; tbl_d[i] = '0; end
    model_reset();
    #1;
    compare_all();
    @(negedge clk);
    reset = 1'b1;
    idle(2);

    // Single entry with an ignored scratch store first
    load(0, 32'd84, 32'd2);
    do_start(1);
    store(32'd80, 32'd7);
    check("t1_not_done", done, 1'b0);
    store(32'd84, 32'd2);
    check("t1_pass", pass, 1'b1);
    check("t1_done", done, 1'b1);
    check("t1_mc", match_count, 4'd1);
    check("t1_code", fail_code, 3'd0);

    // Three entries matched in order
    load(0, 32'h10, 32'd5);
    load(1, 32'h14, 32'd9);
    load(2, 32'h18, 32'hFFFF_FFFF);
    do_start(3);
    store(32'h10, 32'd5);
    check("t2_mc1", match_count, 4'd1);
    store(32'h14, 32'd9);
    check("t2_mc2", match_count, 4'd2);
    check("t2_not_done", done, 1'b0);
    store(32'h18, 32'hFFFF_FFFF);
    check("t2_mc3", match_count, 4'd3);
    check("t2_pass", pass, 1'b1);

    // Bad data on second entry
    do_start(3);
    store(32'h10, 32'd5);
    store(32'h14, 32'd8);
    check("t3_fail", fail, 1'b1);
    check("t3_code", fail_code, 3'd2);
    check("t3_faddr", fail_addr, 32'h14);
    check("t3_fdata", fail_data, 32'd8);
    check("t3_mc", match_count, 4'd1);

    // Unexpected address, then a clean re-run clears the fail fields
    do_start(1);
    store(32'h40, 32'd1);
    check("t4_code", fail_code, 3'd1);
    check("t4_faddr", fail_addr, 32'h40);
    do_start(1);
    store(32'h10, 32'd5);
    check("t4_pass", pass, 1'b1);
    check("t4_fail_clr", fail, 1'b0);
    check("t4_code_clr", fail_code, 3'd0);
    check("t4_faddr_clr", fail_addr, 32'h0);

    // Timeout exactly TO cycles after start, then a last-cycle match wins
    do_start(1);
    idle(TO - 1);
    check("t5_pre_timeout", done, 1'b0);
    idle(1);
    check("t5_timeout_code", fail_code, 3'd3);
    check("t5_timeout_fail", fail, 1'b1);
    do_start(1);
    idle(TO - 1);
    store(32'h10, 32'd5);
    check("t5_edge_pass", pass, 1'b1);
    check("t5_edge_code", fail_code, 3'd0);

    // Bad configuration
    do_start(0);
    check("t6_cfg0", fail_code, 3'd4);
    do_start(9);
    check("t6_cfg9", fail_code, 3'd4);
    check("t6_cfg_done", done, 1'b1);

    // Reset while ARMED; table survives
    do_start(1);
    idle(3);
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    compare_all();
    check("t7_rst_done", done, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    do_start(1);
    store(32'h10, 32'd5);
    check("t7_retained_pass", pass, 1'b1);

    // Table write lands in the same cycle as start
    exp_we = 1'b1; exp_idx = 3'd0; exp_addr = 32'h30; exp_data = 32'd3;
    do_start(1);
    exp_we = 1'b0;
    store(32'h30, 32'd3);
    check("t8_we_start_pass", pass, 1'b1);

    // Table writes while ARMED are ignored
    do_start(1);
    load(0, 32'h50, 32'd6);
    store(32'h30, 32'd3);
    check("t9_armed_we_ignored", pass, 1'b1);

    // Randomized transactions against the model
    for (int t = 0; t < 60; t++) begin
      int n, r, cfg;
      n = int'($urandom_range(1, 5));
      for (int i = 0; i < n; i++)
        load(i, W'($urandom_range(0, 31) * 4), W'($urandom_range(0, 3)));
      cfg = int'($urandom_range(0, 11));
      do_start(cfg == 0 ? 0 : (cfg == 1 ? 9 : n));
      for (int k = 0; k < TO + 4 && m_st == MS_ARMED; k++) begin
        r = int'($urandom_range(0, 99));
        if ($urandom_range(0, 9) == 0) begin
          exp_we = 1'b1; exp_idx = 3'($urandom_range(0, D - 1));
          exp_addr = W'($urandom_range(0, 31) * 4); exp_data = W'($urandom_range(0, 3));
        end
        memwrite = 1'b1;
        if (r < 45) begin
          dataadr = tbl_a[m_next]; writedata = tbl_d[m_next];
        end else if (r < 60) begin
          dataadr = W'(IGN); writedata = $urandom;
        end else if (r < 70) begin
          dataadr = tbl_a[m_next]; writedata = tbl_d[m_next] ^ W'(1);
        end else if (r < 78) begin
          dataadr = W'($urandom_range(0, 31) * 4); writedata = W'($urandom_range(0, 3));
        end else begin
          memwrite = 1'b0;
        end
        cyc();
        memwrite = 1'b0;
        exp_we = 1'b0;
      end
      check("rand_resolved", (m_st != MS_ARMED), 1'b1);
      idle(int'($urandom_range(0, 2)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
